// File: rtl/wb_av_bridge_pkg.sv
// Shared types for the Wishbone-to-Avalon bridge: FSM state encoding and
// Wishbone cycle-type identifiers.
package wb_av_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2
  } bridge_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_to_avalon_bridge.sv
// Wishbone B3 slave to Avalon-MM master bridge: one registered single-beat Avalon
// transfer per Wishbone beat. Define WB_AV_BRIDGE_TIMEOUT_EN for the hung-transfer watchdog.
module wb_to_avalon_bridge
  import wb_av_bridge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BCW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [AW-1:0]     wbs_adr_i,
  input  logic [DW-1:0]     wbs_dat_i,
  input  logic [DW/8-1:0]   wbs_sel_i,
  input  logic              wbs_we_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic [2:0]        wbs_cti_i,
  input  logic [1:0]        wbs_bte_i,
  output logic [DW-1:0]     wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              wbs_rty_o,
  output logic [AW-1:0]     m_av_address_o,
  output logic [DW/8-1:0]   m_av_byteenable_o,
  output logic              m_av_read_o,
  output logic              m_av_write_o,
  output logic [DW-1:0]     m_av_writedata_o,
  output logic [BCW-1:0]    m_av_burstcount_o,
  input  logic [DW-1:0]     m_av_readdata_i,
  input  logic              m_av_waitrequest_i,
  input  logic              m_av_readdatavalid_i
);

  localparam int BW = DW / 8;

  bridge_state_e   state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic            lost;
  logic            timeout;

`ifdef WB_AV_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Count reaches TIMEOUT on the edge that ends the transfer.
  assign timeout = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // A master that has left the cycle gets no response for the beat in flight.
  assign lost = abort_q | ~wbs_cyc_i;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    read_d  = read_q;
    write_d = write_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && !ack_q && !err_q) begin
          adr_d   = wbs_adr_i;
          be_d    = wbs_sel_i;
          wdat_d  = wbs_dat_i;
          abort_d = 1'b0;
          write_d = wbs_we_i;
          read_d  = ~wbs_we_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (!m_av_waitrequest_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            ack_d   = ~lost;
            state_d = IDLE;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (m_av_readdatavalid_i) begin
          rdat_d  = m_av_readdata_i;
          ack_d   = ~lost;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A normal completion on the same edge wins over the watchdog.
    if (timeout && state_d != IDLE) begin
      read_d  = 1'b0;
      write_d = 1'b0;
      ack_d   = 1'b0;
      err_d   = ~lost;
      state_d = IDLE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      read_q  <= read_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign wbs_dat_o         = rdat_q;
  assign wbs_ack_o         = ack_q;
  assign wbs_err_o         = err_q;
  assign wbs_rty_o         = 1'b0;
  assign m_av_address_o    = adr_q;
  assign m_av_byteenable_o = be_q;
  assign m_av_read_o       = read_q;
  assign m_av_write_o      = write_q;
  assign m_av_writedata_o  = wdat_q;
  assign m_av_burstcount_o = BCW'(1);

  // Burst hints are deliberately ignored; each beat is served as a classic cycle.
  logic unused_ok;
  assign unused_ok = ^{wbs_cti_i, wbs_bte_i, CTI_CLASSIC, CTI_INCR, CTI_EOB, TIMEOUT};

endmodule

// File: tb/tb_wb_to_avalon_bridge.sv
// Self-checking bench for wb_to_avalon_bridge: Wishbone master tasks, an Avalon slave
// model with configurable wait/latency, and scoreboards for commands and read data.
module tb_wb_to_avalon_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_w = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [2:0]  wb_cti = '0;
  logic [1:0]  wb_bte = '0;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err, wb_rty;
  logic [31:0] av_addr, av_wdata;
  logic [3:0]  av_be;
  logic        av_read, av_write;
  logic [2:0]  av_burst;
  logic [31:0] av_rdata = '0;
  logic        av_waitreq = 1'b0, av_rdv = 1'b0;

  always #5 clk = ~clk;

  wb_to_avalon_bridge #(.AW(32), .DW(32), .BCW(3), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat_w), .wbs_sel_i(wb_sel), .wbs_we_i(wb_we),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_cti_i(wb_cti), .wbs_bte_i(wb_bte),
    .wbs_dat_o(wb_dat_r), .wbs_ack_o(wb_ack), .wbs_err_o(wb_err), .wbs_rty_o(wb_rty),
    .m_av_address_o(av_addr), .m_av_byteenable_o(av_be), .m_av_read_o(av_read),
    .m_av_write_o(av_write), .m_av_writedata_o(av_wdata), .m_av_burstcount_o(av_burst),
    .m_av_readdata_i(av_rdata), .m_av_waitrequest_i(av_waitreq),
    .m_av_readdatavalid_i(av_rdv)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];      // expected Wishbone read data, in order
  logic [68:0] cmd_q[$];      // expected Avalon commands {write, addr, be, wdata}
  logic [31:0] mem [logic [31:0]];
  int wait_cfg = 0;
  int lat_cfg  = 1;
  bit stall    = 1'b0;
  int acks = 0, errs = 0, rd_cycles = 0, wr_cycles = 0, rdv_count = 0;

  // Avalon slave model: sampled and driven on the falling edge.
  initial begin : slave
    int wait_left, pend;
    logic [31:0] pdata, word;
    logic [68:0] c, got;
    wait_left = 0; pend = 0; pdata = '0;
    forever begin
      @(negedge clk);
      av_rdv = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          av_rdv = 1'b1; av_rdata = pdata; rdv_count++;
        end
      end
      if (av_read || av_write) begin
        if (av_read) rd_cycles++;
        if (av_write) wr_cycles++;
        if (stall || wait_left > 0) begin
          av_waitreq = 1'b1;
          if (wait_left > 0) wait_left--;
        end else begin
          av_waitreq = 1'b0;
          checks++;
          got = {av_write, av_addr, av_be, av_write ? av_wdata : 32'h0};
          if (cmd_q.size() == 0) begin
            errors++;
            $display("FAIL avalon_cmd: unexpected command got=%h", got);
          end else begin
            c = cmd_q.pop_front();
            if (got !== c || av_burst !== 3'd1 || av_read !== ~av_write) begin
              errors++;
              $display("FAIL avalon_cmd: got=%h burst=%0d rd=%b required=%h burst=1",
                       got, av_burst, av_read, c);
            end
          end
          if (av_read) begin
            pend  = lat_cfg;
            pdata = mem.exists(av_addr) ? mem[av_addr] : 32'h0;
          end else begin
            word = mem.exists(av_addr) ? mem[av_addr] : 32'h0;
            for (int b = 0; b < 4; b++) if (av_be[b]) word[8*b +: 8] = av_wdata[8*b +: 8];
            mem[av_addr] = word;
          end
        end
      end else begin
        av_waitreq = 1'b0;
        wait_left  = wait_cfg;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (wb_ack) acks++;
      if (wb_err) errs++;
      if (wb_ack && wb_err) begin
        errors++;
        $display("FAIL ack_err_overlap: ack=%b err=%b required not both", wb_ack, wb_err);
      end
      if (wb_rty !== 1'b0) begin
        errors++;
        $display("FAIL rty: got=%b required=0", wb_rty);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  // One Wishbone beat; called at posedge+1, returns one cycle after the ack/err cycle
  // with the beat's signals still driven so the caller can chain or idle.
  task automatic wb_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti,
                         output int lat, output logic got_ack, output logic got_err);
    logic [31:0] e;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr;
    wb_dat_w = dat; wb_sel = sel; wb_cti = cti;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    while (!got_ack && !got_err && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      got_ack = wb_ack; got_err = wb_err;
    end
    checks++;
    if (!got_ack && !got_err) begin
      errors++;
      $display("FAIL beat_response: adr=%h no ack/err within %0d cycles", adr, lat);
    end else if (got_ack && !we) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_data: adr=%h got=%h required=<none queued>", adr, wb_dat_r);
      end else begin
        e = exp_q.pop_front();
        if (wb_dat_r !== e) begin
          errors++;
          $display("FAIL read_data: adr=%h got=%h required=%h", adr, wb_dat_r, e);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: ack=%b err=%b required 0 0", wb_ack, wb_err);
    end
  endtask

  task automatic wb_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_ack, wb_err, wb_rty, av_read, av_write} !== 5'b0 || wb_dat_r !== 32'h0 ||
        av_addr !== 32'h0 || av_be !== 4'h0 || av_wdata !== 32'h0 || av_burst !== 3'd1) begin
      errors++;
      $display("FAIL reset_values: ack=%b err=%b rd=%b wr=%b dat=%h adr=%h be=%h wd=%h bc=%0d required zeros bc=1",
               wb_ack, wb_err, av_read, av_write, wb_dat_r, av_addr, av_be, av_wdata, av_burst);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_zero_wait();
    int lat; logic a, e;
    wait_cfg = 0; wr_cycles = 0;
    cmd_q.push_back({1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF});
    wb_beat(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b000, lat, a, e);
    wb_idle();
    check_int("write_latency", lat, 2);
    check_int("write_ack", int'(a), 1);
    repeat (2) @(posedge clk); #1;
    check_int("write_strobe_cycles", wr_cycles, 1);
    check_int("write_cmd_consumed", cmd_q.size(), 0);
  endtask

  task automatic test_read_stall();
    int lat, a0; logic a, e;
    wait_cfg = 3; lat_cfg = 2; rd_cycles = 0; a0 = acks;
    mem[32'h0000_2004] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    cmd_q.push_back({1'b0, 32'h0000_2004, 4'hF, 32'h0});
    wb_beat(1'b0, 32'h0000_2004, 32'h0, 4'hF, 3'b000, lat, a, e);
    wb_idle();
    check_int("read_stall_latency", lat, 7);
    repeat (4) @(posedge clk); #1;
    check_int("read_stall_single_ack", acks - a0, 1);
    check_int("read_stall_held_cycles", rd_cycles, 4);
  endtask

  task automatic test_burst();
    int lat, a0; logic a, e; logic [31:0] adr;
    wait_cfg = 0; lat_cfg = 1; rd_cycles = 0; a0 = acks;
    for (int i = 0; i < 4; i++) begin
      adr = 32'h0000_3000 + 32'(4 * i);
      mem[adr] = $urandom;
      exp_q.push_back(mem[adr]);
      cmd_q.push_back({1'b0, adr, 4'hF, 32'h0});
      wb_beat(1'b0, adr, 32'h0, 4'hF, (i == 3) ? 3'b111 : 3'b010, lat, a, e);
      check_int("burst_beat_latency", lat, 3);
    end
    wb_idle();
    repeat (2) @(posedge clk); #1;
    check_int("burst_acks", acks - a0, 4);
    check_int("burst_avalon_reads", rd_cycles, 4);
    check_int("burst_cmd_consumed", cmd_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    int lat, w, l; logic a, e; logic [31:0] adr, d; logic [3:0] s;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 2); wait_cfg = w;
      adr = 32'h0000_5000 + 32'(4 * i); d = $urandom; s = 4'($urandom_range(1, 15));
      cmd_q.push_back({1'b1, adr, s, d});
      wb_beat(1'b1, adr, d, s, 3'b010, lat, a, e);
      check_int("b2b_write_latency", lat, 2 + w);
    end
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 2); l = $urandom_range(1, 3);
      wait_cfg = w; lat_cfg = l;
      adr = 32'h0000_6000 + 32'(4 * i);
      mem[adr] = $urandom;
      exp_q.push_back(mem[adr]);
      cmd_q.push_back({1'b0, adr, 4'hF, 32'h0});
      wb_beat(1'b0, adr, 32'h0, 4'hF, 3'b010, lat, a, e);
      check_int("b2b_read_latency", lat, 2 + w + l);
    end
    wb_idle();
    @(posedge clk); #1;
    check_int("b2b_queues_empty", cmd_q.size() + exp_q.size(), 0);
  endtask

  task automatic test_abort();
    int lat, a0, r0; logic a, e;
    wait_cfg = 3; lat_cfg = 1; rd_cycles = 0; a0 = acks; r0 = rdv_count;
    mem[32'h0000_4000] = 32'hA5A5_0001;
    cmd_q.push_back({1'b0, 32'h0000_4000, 4'hF, 32'h0});
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_4000; wb_sel = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    wb_idle();
    repeat (10) begin @(posedge clk); #1; end
    check_int("abort_no_ack", acks - a0, 0);
    check_int("abort_read_held", rd_cycles, 4);
    check_int("abort_data_consumed", rdv_count - r0, 1);
    check_int("abort_cmd_consumed", cmd_q.size(), 0);
    wait_cfg = 0;
    cmd_q.push_back({1'b1, 32'h0000_4010, 4'h3, 32'h0BAD_CAFE});
    wb_beat(1'b1, 32'h0000_4010, 32'h0BAD_CAFE, 4'h3, 3'b000, lat, a, e);
    wb_idle();
    check_int("after_abort_write_latency", lat, 2);
    mem[32'h0000_4020] = 32'h7777_1111;
    exp_q.push_back(32'h7777_1111);
    cmd_q.push_back({1'b0, 32'h0000_4020, 4'hF, 32'h0});
    wb_beat(1'b0, 32'h0000_4020, 32'h0, 4'hF, 3'b000, lat, a, e);
    wb_idle();
    check_int("after_abort_read_latency", lat, 3);
  endtask

  task automatic test_reset_mid_read();
    int lat, a0, r0; logic a, e;
    wait_cfg = 0; lat_cfg = 3; a0 = acks; r0 = rdv_count;
    mem[32'h0000_7000] = 32'hCAFE_F00D;
    cmd_q.push_back({1'b0, 32'h0000_7000, 4'hF, 32'h0});
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_7000; wb_sel = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_ack, wb_err, av_read, av_write} !== 4'b0 || wb_dat_r !== 32'h0 ||
        av_addr !== 32'h0 || av_be !== 4'h0 || av_burst !== 3'd1) begin
      errors++;
      $display("FAIL async_reset_outputs: ack=%b err=%b rd=%b wr=%b dat=%h adr=%h be=%h bc=%0d required zeros bc=1",
               wb_ack, wb_err, av_read, av_write, wb_dat_r, av_addr, av_be, av_burst);
    end
    wb_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check_int("late_rdv_delivered", rdv_count - r0, 1);
    check_int("late_rdv_no_ack", acks - a0, 0);
    checks++;
    if (wb_dat_r !== 32'h0) begin
      errors++;
      $display("FAIL late_rdv_data_ignored: got=%h required=00000000", wb_dat_r);
    end
    lat_cfg = 1;
    mem[32'h0000_7004] = 32'h0101_2020;
    exp_q.push_back(32'h0101_2020);
    cmd_q.push_back({1'b0, 32'h0000_7004, 4'hF, 32'h0});
    wb_beat(1'b0, 32'h0000_7004, 32'h0, 4'hF, 3'b000, lat, a, e);
    wb_idle();
    check_int("after_reset_read_latency", lat, 3);
  endtask

`ifdef WB_AV_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int lat, a0; logic a, e;
    stall = 1'b1; a0 = acks;
    wb_beat(1'b0, 32'h0000_8000, 32'h0, 4'hF, 3'b000, lat, a, e);
    check_int("timeout_read_dropped", int'(av_read), 0);
    wb_idle();
    stall = 1'b0;
    check_int("timeout_err_latency", lat, TO + 1);
    check_int("timeout_err_seen", int'(e), 1);
    check_int("timeout_no_ack", acks - a0, 0);
    repeat (2) @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_stall();
    test_burst();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();
`ifdef WB_AV_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
